// File: rtl/sensor_frame_sequencer.sv
// sensor_frame_sequencer: frame timing generator producing vsync/hsync blanking and a WIDTH x HEIGHT pixel raster.
module sensor_frame_sequencer #(
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int WIDTH          = 240,
  parameter int HEIGHT         = 240
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  input  logic        stall,
  output logic        vsync,
  output logic        hsync,
  output logic        data_valid,
  output logic [15:0] col,
  output logic [15:0] row,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] VSYNC = 3'd1;
  localparam logic [2:0] HSYNC = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] col_q, col_d, row_q, row_d, frame_cnt_q, frame_cnt_d;
  logic        vsync_q, hsync_q, data_valid_q, frame_done_q, busy_q;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (start && !abort) ? VSYNC : IDLE;
    else if (abort) state_d = IDLE;
    else if (state_q == VSYNC) state_d = (cnt_q == 32'(START_UP_DELAY - 1)) ? HSYNC : VSYNC;
    else if (state_q == HSYNC) state_d = (cnt_q == 32'(HSYNC_DELAY - 1)) ? DATA : HSYNC;
    else if (state_q == DATA)
      state_d = (!stall && col_q == 16'(WIDTH - 1)) ? ((row_q == 16'(HEIGHT - 1)) ? DONE : HSYNC) : DATA;
    else state_d = continuous ? VSYNC : IDLE;
    cnt_d       = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    col_d       = (state_d == DATA && state_q == DATA) ? col_q + {15'd0, !stall} : 16'd0;
    row_d       = (state_d == IDLE || state_d == VSYNC) ? 16'd0 :
                  (state_q == DATA && state_d == HSYNC) ? row_q + 16'd1 : row_q;
    frame_cnt_d = (state_d == DONE) ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_cnt_q  <= '0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_q      <= state_d == VSYNC;
      hsync_q      <= state_d == HSYNC;
      data_valid_q <= state_d == DATA && !(state_q == DATA && stall);
      frame_done_q <= state_d == DONE;
      busy_q       <= state_d != IDLE;
    end
  end
  assign vsync      = vsync_q;
  assign hsync      = hsync_q;
  assign data_valid = data_valid_q;
  assign col        = col_q;
  assign row        = row_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_sensor_frame_sequencer.sv
// tb_sensor_frame_sequencer: randomized and directed checks against a frame-position reference model.
module tb_sensor_frame_sequencer;
  localparam int SU = 3;
  localparam int HD = 2;
  localparam int W  = 4;
  localparam int HT = 2;
  localparam int LN = HD + W;
  localparam int T  = SU + HT * LN + 1;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1, start = 1'b0, continuous = 1'b0, abort = 1'b0, stall = 1'b0;
  logic        vsync, hsync, data_valid, frame_done, busy;
  logic [15:0] col, row, frame_cnt;
  int n_cmp = 0, n_bad = 0;
  bit          m_act = 0, m_hold = 0;
  int          m_pos = 0;
  logic [15:0] m_cnt = 0;
  sensor_frame_sequencer #(.START_UP_DELAY(SU), .HSYNC_DELAY(HD), .WIDTH(W), .HEIGHT(HT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .continuous(continuous), .abort(abort), .stall(stall),
    .vsync(vsync), .hsync(hsync), .data_valid(data_valid), .col(col), .row(row),
    .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt)
  );
  always #5 HCLK = ~HCLK;
  // m_pos counts frame cycles from 1 (first vsync) to T (done); stalls freeze it.
  function automatic bit in_data(int p);
    return p > SU && p < T && ((p - SU - 1) % LN) >= HD;
  endfunction
  function automatic void step(logic r, logic s, logic c, logic a, logic st);
    if (r) begin m_act = 0; m_pos = 0; m_hold = 0; m_cnt = 0; end
    else if (!m_act) begin
      if (s && !a) begin m_act = 1; m_pos = 1; m_hold = 0; end
    end
    else if (a) begin m_act = 0; m_hold = 0; end
    else if (m_pos == T) begin
      m_hold = 0;
      if (c) m_pos = 1; else m_act = 0;
    end
    else if (in_data(m_pos) && st) m_hold = 1;
    else begin
      m_pos++; m_hold = 0;
      if (m_pos == T) m_cnt++;
    end
  endfunction
  function automatic logic [52:0] model_vec();
    int k;
    logic vs, hs, dv, fd;
    logic [15:0] c, r;
    vs = 0; hs = 0; dv = 0; fd = 0; c = 0; r = 0;
    if (m_act) begin
      k = m_pos - SU - 1;
      if (m_pos <= SU) vs = 1;
      else if (m_pos == T) begin fd = 1; r = 16'(HT - 1); end
      else begin
        r = 16'(k / LN);
        if (k % LN < HD) hs = 1;
        else begin dv = !m_hold; c = 16'(k % LN - HD); end
      end
    end
    return {vs, hs, dv, fd, m_act, c, r, m_cnt};
  endfunction
  function automatic logic [52:0] dut_vec();
    return {vsync, hsync, data_valid, frame_done, busy, col, row, frame_cnt};
  endfunction
  task automatic tick(input logic r, input logic s, input logic c, input logic a, input logic st);
    HRESET = r; start = s; continuous = c; abort = a; stall = st;
    @(posedge HCLK);
    step(r, s, c, a, st);
    #1;
  endtask
  task automatic test_reset();
    tick(1, 1, 1, 1, 0);
    tick(1, 0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 53'd0) begin n_bad++; $display("FAIL reset: got %h exp 0", dut_vec()); end
    tick(0, 1, 0, 1, 0);
    n_cmp++;
    if (dut_vec() !== model_vec() || busy !== 1'b0) begin
      n_bad++; $display("FAIL start_with_abort: got %h exp %h", dut_vec(), model_vec());
    end
  endtask
  task automatic test_single_frame(input string tag);
    logic [15:0] base;
    base = m_cnt;
    for (int i = 0; i < 19; i++) begin
      tick(0, i == 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL %s cyc%0d: got %h exp %h", tag, i + 1, dut_vec(), model_vec());
      end
      if (i == 0 || i == 15 || i == 16) begin
        n_cmp++;
        if ((i == 0 && vsync !== 1'b1) || (i == 15 && (frame_done !== 1'b1 || frame_cnt !== base + 16'd1)) ||
            (i == 16 && busy !== 1'b0)) begin
          n_bad++; $display("FAIL %s_timing cyc%0d: vsync=%b done=%b busy=%b cnt=%0d", tag, i + 1,
                            vsync, frame_done, busy, frame_cnt);
        end
      end
    end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 21; i++) begin
      tick(0, i == 0, 0, 0, i == 8 || i == 9);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL stall cyc%0d: got %h exp %h", i + 1, dut_vec(), model_vec());
      end
      if (i == 8 || i == 9 || i == 17) begin
        n_cmp++;
        if ((i != 17 && (col !== 16'd2 || data_valid !== 1'b0)) || (i == 17 && frame_done !== 1'b1)) begin
          n_bad++; $display("FAIL stall_hold cyc%0d: col=%0d valid=%b done=%b", i + 1, col, data_valid, frame_done);
        end
      end
    end
    for (int i = 0; i < 120; i++) begin
      tick(0, $urandom_range(0, 3) == 0, 0, 0, $urandom_range(0, 2) == 0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL stall_rand step%0d: got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask
  task automatic test_abort();
    logic [15:0] base;
    while (busy) tick(0, 0, 0, 0, 0);
    base = m_cnt;
    for (int i = 0; i < 10; i++) tick(0, i == 0, 0, 0, 0);
    n_cmp++;
    if (hsync !== 1'b1 || row !== 16'd1) begin n_bad++; $display("FAIL abort_setup: hsync=%b row=%0d", hsync, row); end
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, i == 0, 0);
      n_cmp++;
      if (dut_vec() !== model_vec() || busy !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== base || row !== 16'd0) begin
        n_bad++; $display("FAIL abort step%0d: got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask
  task automatic test_continuous();
    logic [15:0] base;
    base = m_cnt;
    for (int i = 0; i < 48; i++) begin
      tick(0, i == 0, 1, 0, 0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL cont cyc%0d: got %h exp %h", i + 1, dut_vec(), model_vec());
      end
      if ((i + 1) % 16 == 0 || i == 16 || i == 32) begin
        n_cmp++;
        if (((i + 1) % 16 == 0 && (frame_done !== 1'b1 || frame_cnt !== base + 16'((i + 1) / 16))) ||
            ((i == 16 || i == 32) && vsync !== 1'b1)) begin
          n_bad++; $display("FAIL cont_timing cyc%0d: done=%b vsync=%b cnt=%0d", i + 1, frame_done, vsync, frame_cnt);
        end
      end
    end
    for (int i = 0; i < 18; i++) begin
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL cont_end step%0d: got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) tick(0, i == 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== 53'd0) begin n_bad++; $display("FAIL reset_mid: got %h exp 0", dut_vec()); end
    test_single_frame("after_reset");
  endtask
  task automatic test_wrap();
    @(negedge HCLK);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge HCLK);
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    #1;
    for (int i = 0; i < 17; i++) begin
      tick(0, i == 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL wrap cyc%0d: got %h exp %h", i + 1, dut_vec(), model_vec());
      end
      if (i == 15) begin
        n_cmp++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd0) begin
          n_bad++; $display("FAIL wrap_cnt: done=%b cnt=%0d exp 1/0", frame_done, frame_cnt);
        end
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL random step%0d: got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_frame("single");
    test_stall();
    test_abort();
    test_continuous();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
